// File: rtl/mips_trace_pkg.sv
// rtl/mips_trace_pkg.sv - shared trace record type and field widths for the commit-trace stage
package mips_trace_pkg;

   localparam int TRACE_PC_W   = 32;
   localparam int TRACE_ADDR_W = 5;
   localparam int TRACE_DATA_W = 32;

   typedef struct packed {
      logic [TRACE_PC_W-1:0]   pc;
      logic [TRACE_ADDR_W-1:0] addr;
      logic [TRACE_DATA_W-1:0] data;
   } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO of trace records with wrap-bit pointers
module trace_fifo
   import mips_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  trace_rec_t               wdata,
   output trace_rec_t               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   trace_rec_t     mem [DEPTH];
   logic [AW:0]    wptr;
   logic [AW:0]    rptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count   = wptr - rptr;
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   // Gating on empty keeps the output fields at zero after reset.
   assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - writeback commit-trace buffer; TRACE_ZERO_FILTER_EN drops $0 writes
module wb_trace_buffer
   import mips_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [31:0]       wb_pc,
   input  logic [4:0]        wb_addr,
   input  logic [31:0]       wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [4:0]        out_addr,
   output logic [31:0]       out_data,
   output logic              almost_full,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   trace_rec_t    wrec;
   trace_rec_t    rrec;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          cand;
   logic          pop;
   logic          drop;
   logic          drop_q;

`ifdef TRACE_ZERO_FILTER_EN
   assign cand = wb_valid && (wb_addr != '0);
`else
   assign cand = wb_valid;
`endif

   assign pop  = out_ready && !empty;
   assign drop = cand && full && !pop;
   assign wrec = '{pc: wb_pc, addr: wb_addr, data: wb_data};

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cand),
      .pop   (out_ready),
      .wdata (wrec),
      .rdata (rrec),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign out_valid = !empty;
   assign out_pc    = rrec.pc;
   assign out_addr  = rrec.addr;
   assign out_data  = rrec.data;

   // Drop counter moves on the drop edge; the sticky flag follows one edge later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_count  <= '0;
         drop_q      <= 1'b0;
         overflow    <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (drop && (drop_count != {DROP_W{1'b1}})) drop_count <= drop_count + 1'b1;
         drop_q      <= drop;
         overflow    <= overflow | drop_q;
         almost_full <= (count >= CW'(DEPTH - 2));
      end
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - scoreboard bench for wb_trace_buffer
module tb_wb_trace_buffer;
   import mips_trace_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        almost_full;
   logic        overflow;
   logic [3:0]  drop_count;

   int          checks = 0;
   int          errors = 0;
   trace_rec_t  exp_q[$];

   always #5 clk = ~clk;

   wb_trace_buffer #(.DEPTH(16), .DROP_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_valid    (wb_valid),
      .wb_pc       (wb_pc),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d,
                       input bit accept);
      wb_valid = 1'b1;
      wb_pc    = pc;
      wb_addr  = a;
      wb_data  = d;
      if (accept) exp_q.push_back('{pc: pc, addr: a, data: d});
      step();
      wb_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
      step();
   endtask

   // Monitor: every accepted head record must match the oldest expected one.
   initial begin
      trace_rec_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: got pc=0x%0h addr=%0d data=0x%0h, expected no record",
                        out_pc, out_addr, out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_pc, out_addr, out_data} !== e) begin
                  errors++;
                  $display("FAIL record: got pc=0x%0h addr=%0d data=0x%0h, expected pc=0x%0h addr=%0d data=0x%0h",
                           out_pc, out_addr, out_data, e.pc, e.addr, e.data);
               end
            end
         end
      end
   end

   initial begin
      reset     = 1'b0;
      wb_valid  = 1'b0;
      wb_pc     = '0;
      wb_addr   = '0;
      wb_data   = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid",   32'(out_valid),   0);
      chk("rst_almost_full", 32'(almost_full), 0);
      chk("rst_overflow",    32'(overflow),    0);
      chk("rst_drop_count",  32'(drop_count),  0);
      chk("rst_out_pc",      out_pc,           0);
      chk("rst_out_addr",    32'(out_addr),    0);
      chk("rst_out_data",    out_data,         0);

      // Single record, no bypass, one-cycle latency
      reset     = 1'b1;
      out_ready = 1'b1;
      wb_valid  = 1'b1;
      wb_pc     = 32'h0000_3000;
      wb_addr   = 5'd8;
      wb_data   = 32'h1234_5678;
      exp_q.push_back('{pc: 32'h0000_3000, addr: 5'd8, data: 32'h1234_5678});
      @(negedge clk);
      chk("single_no_bypass", 32'(out_valid), 0);
      step();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("single_valid_next", 32'(out_valid), 1);
      step();
      chk("single_valid_low", 32'(out_valid), 0);
      wait_drain("single_drain");

      // Back-pressure fill, almost_full timing, drops
      out_ready = 1'b0;
      for (int i = 1; i <= 14; i++) push(32'h1000 + 32'(4 * i), 5'(i), 32'hD000_0000 + 32'(i), 1'b1);
      chk("af_not_yet", 32'(almost_full), 0);
      push(32'h1000 + 32'd60, 5'd15, 32'hD000_000F, 1'b1);
      chk("af_risen", 32'(almost_full), 1);
      push(32'h1000 + 32'd64, 5'd16, 32'hD000_0010, 1'b1);
      push(32'hBAD0_0001, 5'd1, 32'hBAD0_0001, 1'b0);
      chk("drop1_count", 32'(drop_count), 1);
      chk("drop1_ovf_late", 32'(overflow), 0);
      push(32'hBAD0_0002, 5'd2, 32'hBAD0_0002, 1'b0);
      push(32'hBAD0_0003, 5'd3, 32'hBAD0_0003, 1'b0);
      chk("drop3_count", 32'(drop_count), 3);
      chk("drop3_overflow", 32'(overflow), 1);

      // Full with simultaneous pop: accepted, occupancy stays 16
      out_ready = 1'b1;
      push(32'hAAAA_0000, 5'd10, 32'hAAAA_0000, 1'b1);
      out_ready = 1'b0;
      chk("fullpop_no_drop", 32'(drop_count), 3);
      push(32'hBAD0_0004, 5'd4, 32'hBAD0_0004, 1'b0);
      chk("fullpop_still_full", 32'(drop_count), 4);
      out_ready = 1'b1;
      wait_drain("bp_drain");
      chk("bp_empty", 32'(out_valid), 0);

      // $0 write
`ifdef TRACE_ZERO_FILTER_EN
      push(32'h0000_4000, 5'd0, 32'hFFFF_FFFF, 1'b0);
      step();
      chk("zero_filtered", 32'(out_valid), 0);
      chk("zero_no_drop", 32'(drop_count), 4);
`else
      push(32'h0000_4000, 5'd0, 32'hFFFF_FFFF, 1'b1);
      wait_drain("zero_emerges");
`endif

      // Saturation of the 4-bit drop counter
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(32'h2000 + 32'(4 * i), 5'(i + 1), 32'hC000_0000 + 32'(i), 1'b1);
      for (int i = 0; i < 20; i++) push(32'hDEAD_0000, 5'd7, 32'(i), 1'b0);
      chk("sat_count", 32'(drop_count), 15);
      push(32'hDEAD_0001, 5'd7, 32'h1, 1'b0);
      chk("sat_held", 32'(drop_count), 15);
      out_ready = 1'b1;
      wait_drain("sat_drain");

      // Reset mid-stream with 5 queued and a push in the reset cycle
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(32'h5000 + 32'(4 * i), 5'd3, 32'(i), 1'b0);
      reset = 1'b0;
      push(32'h5555_5555, 5'd5, 32'h5555_5555, 1'b0);
      reset = 1'b1;
      chk("midrst_out_valid",  32'(out_valid),   0);
      chk("midrst_overflow",   32'(overflow),    0);
      chk("midrst_drop_count", 32'(drop_count),  0);
      chk("midrst_af",         32'(almost_full), 0);
      out_ready = 1'b1;
      push(32'h0000_6000, 5'd9, 32'h6666_6666, 1'b1);
      wait_drain("midrst_first");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
